// File: rtl/core_pkg.sv
// Shared writeback-path types and sizing helpers for the register writeback sink
// and its queue.
package core_pkg;

  localparam int CORE_DATABITWIDTH    = 16;
  localparam int CORE_REGADDRBITWIDTH = 4;
  localparam int REGCOUNT             = 2 ** CORE_REGADDRBITWIDTH;

  typedef struct packed {
    logic [CORE_REGADDRBITWIDTH-1:0] addr;
    logic [CORE_DATABITWIDTH-1:0]    data;
  } wb_entry_t;

  // Pointer/count width: one extra bit so the count can hold QUEUEDEPTH itself.
  function automatic int queuePtrWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/writeback_queue.sv
// In-order FIFO of writeback entries. It exposes every slot, the head pointer
// and the count so that the owner can search queued writes.
module writeback_queue
  import core_pkg::*;
#(
  parameter type EntryT     = wb_entry_t,
  parameter int  QUEUEDEPTH = 2,
  localparam int PtrWidth   = queuePtrWidth(QUEUEDEPTH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  EntryT                        pushEntry,
  input  logic                         pop,
  output EntryT                        headEntry,
  output logic                         full,
  output logic                         empty,
  output logic [PtrWidth-1:0]          headPtr,
  output logic [PtrWidth-1:0]          count,
  output EntryT [QUEUEDEPTH-1:0]       entries
);

  localparam int IdxWidth = PtrWidth - 1;

  EntryT [QUEUEDEPTH-1:0] mem;
  logic [PtrWidth-1:0]    headQ;
  logic [PtrWidth-1:0]    tailQ;
  logic [PtrWidth-1:0]    countQ;
  logic                   doPush;
  logic                   doPop;

  function automatic logic [PtrWidth-1:0] nextPtr(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(QUEUEDEPTH - 1)) ? PtrWidth'(0) : p + PtrWidth'(1);
  endfunction

  assign empty     = (countQ == PtrWidth'(0));
  assign full      = (countQ == PtrWidth'(QUEUEDEPTH));
  // A full queue may still take a push when the head leaves in the same cycle.
  assign doPop     = pop && !empty;
  assign doPush    = push && (!full || doPop);
  assign headEntry = mem[headQ[IdxWidth-1:0]];
  assign headPtr   = headQ;
  assign count     = countQ;
  assign entries   = mem;

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      headQ  <= '0;
      tailQ  <= '0;
      countQ <= '0;
    end else begin
      if (doPush) begin
        mem[tailQ[IdxWidth-1:0]] <= pushEntry;
        tailQ                    <= nextPtr(tailQ);
      end
      if (doPop) begin
        headQ <= nextPtr(headQ);
      end
      case ({doPush, doPop})
        2'b10:   countQ <= countQ + PtrWidth'(1);
        2'b01:   countQ <= countQ - PtrWidth'(1);
        default: countQ <= countQ;
      endcase
    end
  end

endmodule

// File: rtl/register_writeback_sink.sv
// Writeback sink: queues writes, commits one per cycle into the register file,
// and tracks pending destinations. Define WRITEBACK_BYPASS_EN to let reads see queued data.
module register_writeback_sink
  import core_pkg::*;
#(
  parameter int DATABITWIDTH    = CORE_DATABITWIDTH,
  parameter int REGADDRBITWIDTH = CORE_REGADDRBITWIDTH,
  parameter int QUEUEDEPTH      = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       WritebackValid,
  output logic                       WritebackReady,
  input  logic [REGADDRBITWIDTH-1:0] WritebackAddr,
  input  logic [DATABITWIDTH-1:0]    WritebackData,
  input  logic                       CommitHold,
  input  logic                       IssueValid,
  input  logic [REGADDRBITWIDTH-1:0] IssueDestAddr,
  input  logic [REGADDRBITWIDTH-1:0] ReadAAddr,
  output logic [DATABITWIDTH-1:0]    ReadAData,
  output logic                       ReadAPending,
  input  logic [REGADDRBITWIDTH-1:0] ReadBAddr,
  output logic [DATABITWIDTH-1:0]    ReadBData,
  output logic                       ReadBPending,
  output logic                       QueueEmpty
);

  localparam int RegCount = 2 ** REGADDRBITWIDTH;
  localparam int PtrWidth = queuePtrWidth(QUEUEDEPTH);

  typedef struct packed {
    logic [REGADDRBITWIDTH-1:0] addr;
    logic [DATABITWIDTH-1:0]    data;
  } entryT;

  logic [DATABITWIDTH-1:0] regFile [RegCount];
  logic [RegCount-1:0]     pendingQ;
  logic [RegCount-1:0]     clearMask;
  logic [RegCount-1:0]     setMask;
  entryT                   pushEntry;
  entryT                   headEntry;
  entryT [QUEUEDEPTH-1:0]  queueEntries;
  logic [PtrWidth-1:0]     queueHead;
  logic [PtrWidth-1:0]     queueCount;
  logic                    queueFull;
  logic                    queueEmpty;
  logic                    drain;
  logic                    accept;
  logic                    push;

  assign drain          = !queueEmpty && !CommitHold;
  assign WritebackReady = !queueFull || drain;
  assign accept         = WritebackValid && WritebackReady;
  // r0 writes complete the handshake but never occupy a slot.
  assign push           = accept && (WritebackAddr != '0);
  assign pushEntry      = '{addr: WritebackAddr, data: WritebackData};
  assign QueueEmpty     = queueEmpty;

  writeback_queue #(
    .EntryT    (entryT),
    .QUEUEDEPTH(QUEUEDEPTH)
  ) uQueue (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pushEntry(pushEntry),
    .pop      (drain),
    .headEntry(headEntry),
    .full     (queueFull),
    .empty    (queueEmpty),
    .headPtr  (queueHead),
    .count    (queueCount),
    .entries  (queueEntries)
  );

  // Commit the head entry into the architectural register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RegCount; i++) begin
        regFile[i] <= '0;
      end
    end else if (drain && (headEntry.addr != '0)) begin
      regFile[headEntry.addr] <= headEntry.data;
    end
  end

  // Scoreboard masks: commit clears, issue sets; set is applied last so it wins.
  always_comb begin
    clearMask = '0;
    setMask   = '0;
    if (drain) begin
      clearMask[headEntry.addr] = 1'b1;
    end else begin
      clearMask = '0;
    end
    if (IssueValid && (IssueDestAddr != '0)) begin
      setMask[IssueDestAddr] = 1'b1;
    end else begin
      setMask = '0;
    end
  end

  // Pending scoreboard state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pendingQ <= '0;
    end else begin
      pendingQ <= (pendingQ & ~clearMask) | setMask;
    end
  end

  assign ReadAPending = pendingQ[ReadAAddr];
  assign ReadBPending = pendingQ[ReadBAddr];

`ifdef WRITEBACK_BYPASS_EN
  // Walk from oldest to youngest so the youngest matching entry overrides.
  function automatic logic [DATABITWIDTH-1:0] lookup(
    input logic [REGADDRBITWIDTH-1:0] addr,
    input logic [DATABITWIDTH-1:0]    arrayData,
    input entryT [QUEUEDEPTH-1:0]     ents,
    input logic [PtrWidth-1:0]        head,
    input logic [PtrWidth-1:0]        cnt
  );
    logic [DATABITWIDTH-1:0] result;
    logic [PtrWidth-1:0]     slot;
    result = arrayData;
    for (int i = 0; i < QUEUEDEPTH; i++) begin
      slot = PtrWidth'((int'(head) + i) % QUEUEDEPTH);
      if ((i < int'(cnt)) && (ents[slot[PtrWidth-2:0]].addr == addr)) begin
        result = ents[slot[PtrWidth-2:0]].data;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

  // Read muxes with queued-write bypass.
  always_comb begin
    ReadAData = '0;
    ReadBData = '0;
    if (ReadAAddr == '0) begin
      ReadAData = '0;
    end else begin
      ReadAData = lookup(ReadAAddr, regFile[ReadAAddr], queueEntries, queueHead, queueCount);
    end
    if (ReadBAddr == '0) begin
      ReadBData = '0;
    end else begin
      ReadBData = lookup(ReadBAddr, regFile[ReadBAddr], queueEntries, queueHead, queueCount);
    end
  end
`else
  logic unusedQueueView;
  assign unusedQueueView = ^{queueEntries, queueHead, queueCount};

  // Read muxes from the register file only.
  always_comb begin
    ReadAData = '0;
    ReadBData = '0;
    if (ReadAAddr == '0) begin
      ReadAData = '0;
    end else begin
      ReadAData = regFile[ReadAAddr];
    end
    if (ReadBAddr == '0) begin
      ReadBData = '0;
    end else begin
      ReadBData = regFile[ReadBAddr];
    end
  end
`endif

endmodule
